// File: rtl/fetch_unit.sv
// Gumnut fetch stage: PC register, instruction-memory req/ack fetch, return-address stack.
// Latency: one FETCH cycle (or more, until ack) plus one HOLD cycle per instruction.
// Backpressure: FETCH waits for imem_ack_i with req held; HOLD waits for advance_i.
module fetch_unit #(
  parameter int ADDR_W      = 12,
  parameter int INSTR_W     = 18,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  next_pc_i,
  input  logic               advance_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               stack_overflow_o,
  output logic               stack_underflow_o
);

  // Stack depth is a power of two (>= 2) so the pointer wraps naturally.
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]   sp;        // next free slot; top is sp-1
  logic [CNT_W-1:0]   count;     // valid entries, saturates at STACK_DEPTH

  logic               adv;
  logic               empty;
  logic               full;
  logic               do_push;
  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   wr_idx;
  logic [ADDR_W-1:0]  top;
  logic [ADDR_W-1:0]  ret_addr;

  assign adv      = (state == HOLD) && advance_i;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign top_idx  = sp - PTR_W'(1);
  assign top      = stack_mem[top_idx];
  assign ret_addr = pc_o + ADDR_W'(1);   // wraps modulo 2^ADDR_W
  assign do_push  = adv && push_i;
  // A push paired with a successful pop replaces the top in place.
  assign wr_idx   = (pop_i && !empty) ? top_idx : sp;

  // Request is decoded from state so an async reset drops it at once.
  assign imem_req_o  = (state == FETCH);
  assign imem_addr_o = pc_o;

  // Fetch FSM, PC register, stack pointer/count and sticky error flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      pc_o              <= '0;
      instr_o           <= '0;
      instr_valid_o     <= 1'b0;
      sp                <= '0;
      count             <= '0;
      stack_overflow_o  <= 1'b0;
      stack_underflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack_i) begin
            instr_o       <= imem_data_i;
            instr_valid_o <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (advance_i) begin
            instr_valid_o <= 1'b0;
            state         <= FETCH;
            if (pop_i && !empty) pc_o <= top;
            else                 pc_o <= next_pc_i;
            if (pop_i && empty) stack_underflow_o <= 1'b1;
            if (push_i && pop_i && !empty) begin
              // top swapped in place; pointer and count unchanged
            end else if (push_i) begin
              sp <= sp + PTR_W'(1);
              if (full) stack_overflow_o <= 1'b1;   // oldest entry overwritten
              else      count <= count + CNT_W'(1);
            end else if (pop_i && !empty) begin
              sp    <= sp - PTR_W'(1);
              count <= count - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return-address storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) stack_mem[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: table of instruction steps plus hand sequences.
// Each step: wait cycles in FETCH, ack, check HOLD, advance with push/pop, check PC/flags.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [11:0] next_pc;
  logic        advance;
  logic        push;
  logic        pop;
  logic [11:0] pc;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [17:0] imem_data;
  logic [17:0] instr;
  logic        instr_valid;
  logic        ovf;
  logic        unf;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] cur_pc;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst), .next_pc_i(next_pc), .advance_i(advance),
    .push_i(push), .pop_i(pop), .pc_o(pc), .imem_req_o(imem_req),
    .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .instr_o(instr), .instr_valid_o(instr_valid),
    .stack_overflow_o(ovf), .stack_underflow_o(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        push;
    logic        pop;
    logic [11:0] npc;
    logic [11:0] exp_pc;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One instruction: fetch with wt wait states, then advance with the given controls.
  task automatic run_step(input int wt, input logic [17:0] data, input logic p_push,
                          input logic p_pop, input logic [11:0] npc,
                          input logic [11:0] exp_pc, input logic eo, input logic eu);
    for (int w = 0; w < wt; w++) begin
      check("req_wait", 32'(imem_req), 1);
      check("addr_wait", 32'(imem_addr), 32'(cur_pc));
      @(negedge clk);
    end
    imem_ack = 1'b1;
    imem_data = data;
    check("req_ack", 32'(imem_req), 1);
    check("addr_ack", 32'(imem_addr), 32'(cur_pc));
    @(negedge clk);
    imem_ack = 1'b0;
    imem_data = 18'h3FFFF;
    check("instr_hold", 32'(instr), 32'(data));
    check("valid_hold", 32'(instr_valid), 1);
    check("req_hold", 32'(imem_req), 0);
    if (wt == 1) begin
      @(negedge clk);
      check("instr_stall", 32'(instr), 32'(data));
      check("pc_stall", 32'(pc), 32'(cur_pc));
    end
    advance = 1'b1;
    push = p_push;
    pop = p_pop;
    next_pc = npc;
    @(negedge clk);
    advance = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    check("pc_adv", 32'(pc), 32'(exp_pc));
    check("valid_adv", 32'(instr_valid), 0);
    check("req_adv", 32'(imem_req), 1);
    check("ovf", 32'(ovf), 32'(eo));
    check("unf", 32'(unf), 32'(eu));
    cur_pc = exp_pc;
  endtask

  initial begin
    // push, pop, next_pc, expected pc, expected overflow, expected underflow
    vecs.push_back('{0, 0, 12'h010, 12'h010, 0, 0});
    vecs.push_back('{1, 0, 12'h200, 12'h200, 0, 0});   // push 0x011
    vecs.push_back('{0, 1, 12'h7AA, 12'h011, 0, 0});   // pop returns 0x011
    vecs.push_back('{0, 1, 12'h020, 12'h020, 0, 1});   // empty pop underflows
    vecs.push_back('{0, 0, 12'h100, 12'h100, 0, 1});
    for (int k = 0; k < 9; k++)                         // pushes at 0x100..0x108
      vecs.push_back('{1, 0, 12'h101 + 12'(k), 12'h101 + 12'(k), (k == 8), 1});
    for (int k = 0; k < 8; k++)                         // pops return 0x109..0x102
      vecs.push_back('{0, 1, 12'h3C3, 12'h109 - 12'(k), 1, 1});
    vecs.push_back('{0, 1, 12'h3C3, 12'h3C3, 1, 1});    // ninth pop underflows
    vecs.push_back('{0, 0, 12'hFFF, 12'hFFF, 1, 1});
    vecs.push_back('{1, 0, 12'h050, 12'h050, 1, 1});    // push 0xFFF+1 = 0x000
    vecs.push_back('{0, 1, 12'h123, 12'h000, 1, 1});
    vecs.push_back('{0, 0, 12'h054, 12'h054, 1, 1});
    vecs.push_back('{1, 0, 12'h300, 12'h300, 1, 1});    // top = 0x055
    vecs.push_back('{1, 1, 12'h777, 12'h055, 1, 1});    // swap: top becomes 0x301
    vecs.push_back('{0, 1, 12'h777, 12'h301, 1, 1});
    vecs.push_back('{0, 1, 12'h444, 12'h444, 1, 1});    // count was 1 -> now empty

    rst = 1'b1;
    next_pc = '0;
    advance = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    imem_ack = 1'b0;
    imem_data = '0;
    cur_pc = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", 32'(pc), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_unf", 32'(unf), 0);

    rst = 1'b0;
    check("idle_req", 32'(imem_req), 0);
    @(negedge clk);

    // Reset release, memory acks in the third request cycle; then advance to 0x0A0.
    run_step(2, 18'h12345, 1'b0, 1'b0, 12'h0A0, 12'h0A0, 1'b0, 1'b0);
    check("addr_0a0", 32'(imem_addr), 32'h0A0);

    // advance/push/pop in FETCH are ignored.
    advance = 1'b1;
    push = 1'b1;
    next_pc = 12'h333;
    @(negedge clk);
    advance = 1'b0;
    push = 1'b0;
    check("fetch_adv_pc", 32'(pc), 32'h0A0);
    check("fetch_adv_req", 32'(imem_req), 1);
    check("fetch_adv_valid", 32'(instr_valid), 0);

    foreach (vecs[i])
      run_step(i % 3, 18'h20000 ^ 18'(i * 37), vecs[i].push, vecs[i].pop,
               vecs[i].npc, vecs[i].exp_pc, vecs[i].exp_ovf, vecs[i].exp_unf);

    // Reset during FETCH with an ack present: everything clears immediately.
    imem_ack = 1'b1;
    imem_data = 18'h2AAAA;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 0);
    check("arst_pc", 32'(pc), 0);
    check("arst_valid", 32'(instr_valid), 0);
    check("arst_instr", 32'(instr), 0);
    @(negedge clk);
    check("arst_instr_edge", 32'(instr), 0);
    check("arst_ovf", 32'(ovf), 0);
    check("arst_unf", 32'(unf), 0);
    imem_ack = 1'b0;
    rst = 1'b0;
    check("arst_idle_req", 32'(imem_req), 0);
    @(negedge clk);
    cur_pc = '0;
    check("restart_addr", 32'(imem_addr), 0);
    run_step(0, 18'h15555, 1'b0, 1'b0, 12'h00F, 12'h00F, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter register and instruction-fetch stage of the Gumnut core.
- Holds the architectural PC and drives it to the next-PC logic (its PC_i) and to instruction memory over a req/ack handshake.
- Latches the fetched instruction for the decoder, and loads the next-PC result when the core retires the current instruction.
- Contains the return-address stack used by jsb/ret.

Parameters:
ADDR_W, 12, PC / instruction-memory address width
INSTR_W, 18, instruction word width
STACK_DEPTH, 8, return-address stack entries (power of two)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
next_pc_i  input  ADDR_W  next PC computed by next-PC logic
advance_i  input  1  current instruction retired; load new PC
push_i  input  1  jsb: push pc_o+1 on advance
pop_i  input  1  ret: take PC from stack top on advance
pc_o  output  ADDR_W  current PC (to next-PC logic PC_i)
imem_req_o  output  1  fetch request
imem_addr_o  output  ADDR_W  fetch address (= pc_o)
imem_ack_i  input  1  instruction memory data valid
imem_data_i  input  INSTR_W  fetched instruction
instr_o  output  INSTR_W  latched instruction to decoder
instr_valid_o  output  1  instr_o holds the instruction at pc_o
stack_overflow_o  output  1  sticky: push while stack full
stack_underflow_o  output  1  sticky: pop while stack empty

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values:
  - pc_o=0, instr_o=0, instr_valid_o=0, imem_req_o=0.
  - Both flags 0; stack count 0, stack pointer 0.
  - State IDLE.
- State machine (IDLE, FETCH, HOLD):
  - IDLE -> FETCH on the first clock edge after reset deasserts.
  - FETCH:
    - imem_req_o=1 (decoded from state); imem_addr_o=pc_o.
    - On imem_ack_i=1: instr_o<=imem_data_i, instr_valid_o<=1, state HOLD.
    - Ack in the first FETCH cycle is legal (zero wait states). Without ack, the stage stays in FETCH indefinitely, req held high.
  - HOLD:
    - imem_req_o=0; instr_o stable.
    - On advance_i=1: PC updated (rules below), instr_valid_o<=0, state FETCH.
- advance_i, push_i and pop_i are ignored outside HOLD. push_i/pop_i act only in the same cycle as advance_i.
- PC update on advance:
  - pop_i=1 with stack non-empty: pc_o<=stack top, count decrements.
  - pop_i=1 with stack empty: pc_o<=next_pc_i, stack_underflow_o<=1, count stays 0.
  - Otherwise: pc_o<=next_pc_i.
- push_i=1 without pop: pc_o+1 written at top, count increments.
  - Return address is computed modulo 2^ADDR_W: 0xFFF -> 0x000.
- Push while count==STACK_DEPTH:
  - Circular stack; the oldest entry is overwritten and count stays STACK_DEPTH.
  - stack_overflow_o<=1.
- push_i and pop_i together: PC<=old top, top replaced by pc_o+1, count unchanged.
  - If the stack is empty, underflow applies (PC<=next_pc_i, flag set) and the push proceeds normally (count becomes 1).
- Overflow/underflow flags are sticky and clear only on reset.
- Fetch latency:
  - Minimum 1 cycle FETCH + 1 cycle HOLD per instruction, i.e. 2 cycles per instruction with a zero-wait memory.
  - pc_o changes only on the advance edge, so the next-PC logic sees a stable PC throughout HOLD.
- Reset mid-FETCH: the request drops immediately (asynchronous), and any ack arriving during reset is ignored.

Test Plan:
1. Reset release, memory acks after 3 cycles with 0x12345 -> imem_req_o high 3 cycles at addr 0x000, then instr_o=0x12345, instr_valid_o=1, imem_req_o=0.
2. HOLD with next_pc_i=0x0A0, advance_i=1 -> next cycle pc_o=0x0A0, instr_valid_o=0, imem_req_o=1, imem_addr_o=0x0A0; holding advance_i in FETCH has no effect.
3. pc_o=0x010, advance+push_i with next_pc_i=0x200 -> pc_o=0x200. A later advance+pop_i -> pc_o=0x011. A second pop -> pc_o=next_pc_i, stack_underflow_o=1 and stays 1.
4. Nine pushes from pc_o=0x100..0x108 -> stack_overflow_o=1 after the 9th. Eight pops return 0x109..0x102; the ninth pop underflows.
5. Push at pc_o=0xFFF -> a later pop loads 0x000. Simultaneous push+pop with top=0x055 at pc_o=0x300 -> pc_o=0x055, new top 0x301, count unchanged.
6. Assert rst_i while in FETCH with imem_ack_i=1 -> outputs return to reset values immediately, instr_o not updated; fetch restarts at 0x000.
